// File: rtl/multicycle_main_fsm.sv
// Main control FSM of a multicycle RISC-V-style core: Moore state machine, opcode
// decode, sticky illegal-opcode indication and a retired-instruction counter.
module multicycle_main_fsm #(
  parameter bit          EN_JALR = 1'b1,
  parameter bit          EN_LUI  = 1'b1,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       Op,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             MemReq,
  output logic             MemWrite,
  output logic             AdrSrc,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [2:0]       ImmSrc,
  output logic             Illegal,
  output logic [CNT_W-1:0] InstRet
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpI      = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecR,
    StExecI,
    StAluWb,
    StBeq,
    StJal,
    StJalrAdr,
    StLui,
    StTrap
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] instret_q;
  logic             retire;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch: begin
        if (MemReady) state_d = StDecode;
      end
      StDecode: begin
        case (Op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpR:             state_d = StExecR;
          OpI:             state_d = StExecI;
          OpBranch:        state_d = StBeq;
          OpJal:           state_d = StJal;
          OpJalr:          state_d = EN_JALR ? StJalrAdr : StTrap;
          OpLui:           state_d = EN_LUI ? StLui : StTrap;
          default:         state_d = StTrap;
        endcase
      end
      StMemAdr:   state_d = (Op == OpLoad) ? StMemRead : StMemWrite;
      StMemRead: begin
        if (MemReady) state_d = StMemWb;
      end
      StMemWb:    state_d = StFetch;
      StMemWrite: begin
        if (MemReady) state_d = StFetch;
      end
      StExecR:    state_d = StAluWb;
      StExecI:    state_d = StAluWb;
      StLui:      state_d = StAluWb;
      StAluWb:    state_d = StFetch;
      StBeq:      state_d = StFetch;
      StJalrAdr:  state_d = StJal;
      StJal:      state_d = StAluWb;
      StTrap:     state_d = StTrap;
      default:    state_d = StFetch;
    endcase
  end

  // Moore outputs; Zero and MemReady only qualify the commit cycles of BEQ and FETCH
  always_comb begin
    MemReq    = 1'b0;
    MemWrite  = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    Illegal   = 1'b0;
    case (state_q)
      StFetch: begin
        MemReq = 1'b1;
        if (MemReady) begin
          IRWrite   = 1'b1;
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
          PCWrite   = 1'b1;
        end
      end
      StDecode: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      StMemAdr: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      StMemRead: begin
        MemReq = 1'b1;
        AdrSrc = 1'b1;
      end
      StMemWb: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      StMemWrite: begin
        MemReq   = 1'b1;
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
      end
      StExecR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      StExecI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      StLui: begin
        ALUSrcA = 2'b11;
        ALUSrcB = 2'b01;
      end
      StAluWb: begin
        RegWrite = 1'b1;
      end
      StBeq: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        PCWrite = Zero;
      end
      StJalrAdr: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      StJal: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
      end
      StTrap: begin
        Illegal = 1'b1;
      end
      default: ;
    endcase
  end

  // Immediate type follows the opcode in every state
  always_comb begin
    case (Op)
      OpLoad, OpI, OpJalr: ImmSrc = 3'b000;
      OpStore:             ImmSrc = 3'b001;
      OpBranch:            ImmSrc = 3'b010;
      OpJal:               ImmSrc = 3'b011;
      OpLui:               ImmSrc = 3'b100;
      default:             ImmSrc = 3'b000;
    endcase
  end

  // An instruction retires on the edge that returns the FSM to FETCH
  always_comb begin
    retire = 1'b0;
    case (state_q)
      StMemWb, StAluWb, StBeq: retire = 1'b1;
      StMemWrite:              retire = MemReady;
      default:                 retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instret_q <= '0;
    end else if (retire) begin
      instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign InstRet = instret_q;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Scoreboard bench for multicycle_main_fsm: per-cycle expected control vectors are
// queued per instruction and compared as the FSM walks through its states.
module tb_multicycle_main_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] Op;
  logic       Zero;
  logic       MemReady;

  logic        MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, Illegal;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [2:0]  ImmSrc;
  logic [31:0] InstRet;

  logic        n_memreq, n_memwrite, n_adrsrc, n_irwrite, n_pcwrite, n_regwrite, n_illegal;
  logic [1:0]  n_resultsrc, n_alusrca, n_alusrcb, n_aluop;
  logic [2:0]  n_immsrc;
  logic [31:0] n_instret;

  logic        w_memreq, w_memwrite, w_adrsrc, w_irwrite, w_pcwrite, w_regwrite, w_illegal;
  logic [1:0]  w_resultsrc, w_alusrca, w_alusrcb, w_aluop;
  logic [2:0]  w_immsrc;
  logic [3:0]  w_instret;

  always #5 clk = ~clk;

  multicycle_main_fsm dut (
    .clk(clk), .reset(reset), .Op(Op), .Zero(Zero), .MemReady(MemReady),
    .MemReq(MemReq), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ImmSrc(ImmSrc), .Illegal(Illegal), .InstRet(InstRet)
  );

  multicycle_main_fsm #(.EN_JALR(1'b0)) dut_nojalr (
    .clk(clk), .reset(reset), .Op(Op), .Zero(Zero), .MemReady(MemReady),
    .MemReq(n_memreq), .MemWrite(n_memwrite), .AdrSrc(n_adrsrc), .IRWrite(n_irwrite),
    .PCWrite(n_pcwrite), .RegWrite(n_regwrite), .ResultSrc(n_resultsrc),
    .ALUSrcA(n_alusrca), .ALUSrcB(n_alusrcb), .ALUOp(n_aluop), .ImmSrc(n_immsrc),
    .Illegal(n_illegal), .InstRet(n_instret)
  );

  multicycle_main_fsm #(.CNT_W(4)) dut_w4 (
    .clk(clk), .reset(reset), .Op(Op), .Zero(Zero), .MemReady(MemReady),
    .MemReq(w_memreq), .MemWrite(w_memwrite), .AdrSrc(w_adrsrc), .IRWrite(w_irwrite),
    .PCWrite(w_pcwrite), .RegWrite(w_regwrite), .ResultSrc(w_resultsrc),
    .ALUSrcA(w_alusrca), .ALUSrcB(w_alusrcb), .ALUOp(w_aluop), .ImmSrc(w_immsrc),
    .Illegal(w_illegal), .InstRet(w_instret)
  );

  // {MemReq,MemWrite,AdrSrc,IRWrite,PCWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,Illegal}
  logic [14:0] obs;
  assign obs = {MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                ResultSrc, ALUSrcA, ALUSrcB, ALUOp, Illegal};

  localparam logic [14:0] VFetchW  = {6'b100000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [14:0] VFetchG  = {6'b100110, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0};
  localparam logic [14:0] VDecode  = {6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0};
  localparam logic [14:0] VMemAdr  = {6'b000000, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0};
  localparam logic [14:0] VMemRead = {6'b101000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [14:0] VMemWb   = {6'b000001, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [14:0] VMemWr   = {6'b111000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [14:0] VExecR   = {6'b000000, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0};
  localparam logic [14:0] VExecI   = {6'b000000, 2'b00, 2'b10, 2'b01, 2'b10, 1'b0};
  localparam logic [14:0] VLui     = {6'b000000, 2'b00, 2'b11, 2'b01, 2'b00, 1'b0};
  localparam logic [14:0] VAluWb   = {6'b000001, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [14:0] VBeq     = {6'b000000, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0};
  localparam logic [14:0] VJalrAdr = {6'b000000, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0};
  localparam logic [14:0] VJal     = {6'b000010, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0};
  localparam logic [14:0] VTrap    = {6'b000000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1};

  typedef struct {
    string       tag;
    logic        mr;
    logic        z;
    logic [14:0] v;
  } entry_t;

  entry_t exp_q[$];
  int     n_tests = 0;
  int     n_fail  = 0;
  int     exp_ir  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic rnd();
    return logic'($urandom_range(0, 1));
  endfunction

  function automatic logic [2:0] imm_exp(input logic [6:0] op);
    case (op)
      7'b0000011, 7'b0010011, 7'b1100111: return 3'b000;
      7'b0100011: return 3'b001;
      7'b1100011: return 3'b010;
      7'b1101111: return 3'b011;
      7'b0110111: return 3'b100;
      default:    return 3'b000;
    endcase
  endfunction

  task automatic push(input string tag, input logic mr, input logic z, input logic [14:0] v);
    entry_t e;
    e.tag = tag;
    e.mr  = mr;
    e.z   = z;
    e.v   = v;
    exp_q.push_back(e);
  endtask

  // Called at posedge+1; leaves the bench at posedge+1 after the last queued cycle
  task automatic drain();
    entry_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      MemReady = e.mr;
      Zero     = e.z;
      #1;
      check_val(e.tag, 32'(obs), 32'(e.v));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic instr(input string name, input logic [6:0] op, input logic z,
                       input int fwait, input int mwait);
    Op = op;
    #1;
    check_val({name, ".imm"}, 32'(ImmSrc), 32'(imm_exp(op)));
    for (int i = 0; i < fwait; i++) push({name, ".fetchw"}, 1'b0, rnd(), VFetchW);
    push({name, ".fetch"}, 1'b1, rnd(), VFetchG);
    push({name, ".decode"}, rnd(), rnd(), VDecode);
    case (op)
      7'b0000011: begin
        push({name, ".memadr"}, rnd(), rnd(), VMemAdr);
        for (int i = 0; i < mwait; i++) push({name, ".memrdw"}, 1'b0, rnd(), VMemRead);
        push({name, ".memrd"}, 1'b1, rnd(), VMemRead);
        push({name, ".memwb"}, rnd(), rnd(), VMemWb);
      end
      7'b0100011: begin
        push({name, ".memadr"}, rnd(), rnd(), VMemAdr);
        for (int i = 0; i < mwait; i++) push({name, ".memwrw"}, 1'b0, rnd(), VMemWr);
        push({name, ".memwr"}, 1'b1, rnd(), VMemWr);
      end
      7'b0110011: begin
        push({name, ".execr"}, rnd(), rnd(), VExecR);
        push({name, ".aluwb"}, rnd(), rnd(), VAluWb);
      end
      7'b0010011: begin
        push({name, ".execi"}, rnd(), rnd(), VExecI);
        push({name, ".aluwb"}, rnd(), rnd(), VAluWb);
      end
      7'b1100011: push({name, ".beq"}, rnd(), z, VBeq | {4'b0000, z, 10'b0});
      7'b1101111: begin
        push({name, ".jal"}, rnd(), rnd(), VJal);
        push({name, ".aluwb"}, rnd(), rnd(), VAluWb);
      end
      7'b1100111: begin
        push({name, ".jalradr"}, rnd(), rnd(), VJalrAdr);
        push({name, ".jal"}, rnd(), rnd(), VJal);
        push({name, ".aluwb"}, rnd(), rnd(), VAluWb);
      end
      7'b0110111: begin
        push({name, ".lui"}, rnd(), rnd(), VLui);
        push({name, ".aluwb"}, rnd(), rnd(), VAluWb);
      end
      default: for (int i = 0; i < 3; i++) push({name, ".trap"}, rnd(), rnd(), VTrap);
    endcase
    drain();
    if (op != 7'b1111111) exp_ir++;
    check_val({name, ".instret"}, InstRet, 32'(exp_ir));
    check_val({name, ".instret4"}, 32'(w_instret), 32'(exp_ir % 16));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    Op       = 7'b0000000;
    Zero     = 1'b0;
    MemReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_val("reset.outputs", 32'(obs), 32'(VFetchW));
    check_val("reset.instret", InstRet, 32'd0);

    instr("lw", 7'b0000011, 1'b0, 0, 0);
    instr("lw_wait", 7'b0000011, 1'b0, 2, 2);
    instr("sw", 7'b0100011, 1'b0, 1, 3);
    instr("beq_z1", 7'b1100011, 1'b1, 0, 0);
    instr("beq_z0", 7'b1100011, 1'b0, 0, 0);
    instr("add", 7'b0110011, 1'b0, 0, 0);
    instr("addi", 7'b0010011, 1'b0, 0, 0);
    instr("jal", 7'b1101111, 1'b0, 0, 0);
    instr("lui", 7'b0110111, 1'b0, 0, 0);
    instr("jalr", 7'b1100111, 1'b0, 0, 0);

    // The EN_JALR=0 instance trapped on the jalr above and must stay there
    for (int i = 0; i < 10; i++) begin
      MemReady = 1'b0;
      #1;
      check_val("nojalr.illegal", 32'(n_illegal), 32'd1);
      check_val("idle.fetchw", 32'(obs), 32'(VFetchW));
      @(posedge clk);
      #1;
    end

    instr("illegal", 7'b1111111, 1'b0, 0, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    MemReady = 1'b0;
    #1;
    exp_ir = 0;
    check_val("trapreset.outputs", 32'(obs), 32'(VFetchW));
    check_val("trapreset.instret", InstRet, 32'd0);
    check_val("trapreset.nojalr", 32'(n_illegal), 32'd0);

    // Reset arriving while a store waits on memory
    instr("sw0", 7'b0100011, 1'b0, 0, 0);
    Op = 7'b0100011;
    push("swrst.fetch", 1'b1, 1'b0, VFetchG);
    push("swrst.decode", 1'b0, 1'b0, VDecode);
    push("swrst.memadr", 1'b0, 1'b0, VMemAdr);
    push("swrst.memwrw", 1'b0, 1'b0, VMemWr);
    drain();
    reset    = 1'b1;
    MemReady = 1'b1;
    @(posedge clk);
    #1;
    check_val("swrst.memwrite", 32'(MemWrite), 32'd0);
    check_val("swrst.outputs", 32'(obs), 32'(VFetchG));
    check_val("swrst.instret", InstRet, 32'd0);
    reset    = 1'b0;
    MemReady = 1'b0;
    exp_ir   = 0;

    for (int i = 0; i < 16; i++) instr("wrap_addi", 7'b0010011, 1'b0, 0, 0);
    check_val("wrap.instret4", 32'(w_instret), 32'd0);
    check_val("wrap.instret", InstRet, 32'd16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_main_fsm.md
MULTICYCLE_MAIN_FSM -- requirements
Module: multicycle_main_fsm

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- EN_JALR, 1, jalr (1100111) is a legal opcode.
- EN_LUI, 1, lui (0110111) is a legal opcode.
- CNT_W, 32, width of the InstRet counter.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on its rising edge.
- reset, in, 1, synchronous, active-high.
- Op, in, 7, opcode field from the instruction register.
- Zero, in, 1, ALU zero flag.
- MemReady, in, 1, memory completes the current access.
- MemReq, out, 1, memory access request.
- MemWrite, out, 1, store enable.
- AdrSrc, out, 1, address select: 0=PC, 1=ALUOut.
- IRWrite, out, 1, instruction register load.
- PCWrite, out, 1, PC load.
- RegWrite, out, 1, register file write.
- ResultSrc, out, 2, result select: 00=ALUOut, 01=Data, 10=ALUResult.
- ALUSrcA, out, 2, ALU A select: 00=PC, 01=OldPC, 10=rs1, 11=zero.
- ALUSrcB, out, 2, ALU B select: 00=rs2, 01=imm, 10=constant 4.
- ALUOp, out, 2, ALU control: 00=add, 01=sub/compare, 10=funct-decoded.
- ImmSrc, out, 3, immediate type.
- Illegal, out, 1, sticky illegal-opcode flag.
- InstRet, out, CNT_W, retired-instruction count.

Function
REQ-003 The block SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, JALRADR, LUI, TRAP.
REQ-004 Any control output not listed for the current state SHALL be 0.
REQ-005 FETCH SHALL drive MemReq=1, AdrSrc=0 and hold until MemReady=1. In the MemReady=1 cycle it SHALL also drive IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCWrite=1, then go to DECODE.
REQ-006 DECODE SHALL drive ALUSrcA=01, ALUSrcB=01, ALUOp=00. Next state by Op:
- 0000011 or 0100011 -> MEMADR
- 0110011 -> EXECR
- 0010011 -> EXECI
- 1100011 -> BEQ
- 1101111 -> JAL
- 1100111 -> JALRADR, only if EN_JALR=1
- 0110111 -> LUI, only if EN_LUI=1
- any other or disabled opcode -> TRAP
REQ-007 MEMADR SHALL drive ALUSrcA=10, ALUSrcB=01, ALUOp=00, then go to MEMREAD if Op=0000011, else MEMWRITE.
REQ-008 MEMREAD SHALL drive MemReq=1, AdrSrc=1, ResultSrc=00 and hold until MemReady=1, then go to MEMWB.
REQ-009 MEMWB SHALL drive ResultSrc=01, RegWrite=1, then go to FETCH.
REQ-010 MEMWRITE SHALL drive MemReq=1, MemWrite=1, AdrSrc=1, ResultSrc=00 and hold them steady until MemReady=1, then go to FETCH.
REQ-011 EXECR SHALL drive ALUSrcA=10, ALUSrcB=00, ALUOp=10, then go to ALUWB.
REQ-012 EXECI SHALL drive ALUSrcA=10, ALUSrcB=01, ALUOp=10, then go to ALUWB.
REQ-013 LUI SHALL drive ALUSrcA=11, ALUSrcB=01, ALUOp=00, then go to ALUWB.
REQ-014 ALUWB SHALL drive ResultSrc=00, RegWrite=1, then go to FETCH.
REQ-015 BEQ SHALL drive ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=Zero, then go to FETCH.
REQ-016 JALRADR SHALL drive ALUSrcA=10, ALUSrcB=01, ALUOp=00, then go to JAL.
REQ-017 JAL SHALL drive ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1, then go to ALUWB.
REQ-018 TRAP SHALL assert Illegal=1, hold all enables at 0, and remain in TRAP until reset.
REQ-019 ImmSrc SHALL be combinational from Op in every state:
- 0000011/0010011/1100111 -> 000
- 0100011 -> 001
- 1100011 -> 010
- 1101111 -> 011
- 0110111 -> 100
- otherwise -> 000
REQ-020 InstRet SHALL increment by 1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ, and SHALL wrap modulo 2^CNT_W.
REQ-021 MemReady SHALL be ignored in states other than FETCH, MEMREAD and MEMWRITE.
REQ-022 Cycle counts with MemReady tied high SHALL be: lw 5, sw 4, R/I 4, beq 3, jal 4, jalr 5, lui 4.

Reset
REQ-023 With reset=1 at a clock edge, the next state SHALL be FETCH, Illegal SHALL be 0 and InstRet SHALL be 0, regardless of the current state, including a pending MEMWRITE or MEMREAD wait.
REQ-024 In the cycle after reset deasserts, the outputs SHALL be the FETCH outputs.
REQ-025 MemWrite SHALL be 0 from the first edge with reset=1.

Verification
REQ-026 The bench SHALL cover the following directed scenarios:
- lw, MemReady=1 -> states FETCH,DECODE,MEMADR,MEMREAD,MEMWB; RegWrite=1 with ResultSrc=01 only in cycle 5; InstRet 0->1.
- sw with MemReady low 3 cycles in MEMWRITE -> MemWrite=1, AdrSrc=1 held 4 cycles; then FETCH; RegWrite never 1.
- beq with Zero=1, then beq with Zero=0 -> PCWrite=1 in BEQ for the first, 0 for the second; both 3 cycles.
- jalr with EN_JALR=1 -> DECODE,JALRADR,JAL,ALUWB; with EN_JALR=0 -> TRAP, Illegal=1 persists 10 cycles.
- Op=1111111 -> TRAP; then reset=1 for 1 cycle -> FETCH, Illegal=0, InstRet=0.
- CNT_W=4, 16 addi retires -> InstRet wraps 15->0.
